// File: rtl/seg7_scan_monitor.sv
// seg7_scan_monitor: reads back a multiplexed 4-digit active-low seven-segment
// scan (seg/an). It waits for each digit to settle, decodes it to a hex nibble
// and assembles complete frames into value/blank/valid.
// Optional build macro SEG7_MON_MINUS_EN: decodes the g-only pattern as a
// minus sign and adds the per-digit neg output.
`timescale 1ns/1ps

module seg7_scan_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 65535
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic [3:0]  blank,
  output logic        valid,
  output logic        frame_done,
  output logic        bad_seg
`ifdef SEG7_MON_MINUS_EN
  ,
  output logic [3:0]  neg
`endif
);

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned AN_W   = 4;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDLE_W = 16;
  localparam int unsigned VAL_W  = AN_W * NIB_W;

  localparam logic [CNT_W-1:0]  STABLE_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX    = IDLE_W'(TIMEOUT);

  typedef enum logic {SETTLE, HELD} state_t;

  logic [SEG_W-1:0]  seg_q;
  logic [AN_W-1:0]   an_q;
  logic              change_c;
  logic [CNT_W-1:0]  cnt_q;
  logic              settle_hit_c;
  state_t            state_q, state_d;
  logic              capture_c;
  logic [NIB_W-1:0]  nib_c;
  logic              blank_c;
  logic              bad_c;
  logic [IDX_W-1:0]  idx_c;
  logic              onehot_c;
  logic [VAL_W-1:0]  shadow_q;
  logic [AN_W-1:0]   sblank_q;
  logic [AN_W-1:0]   seen_q;
  logic              frame_bad_q;
  logic [IDLE_W-1:0] idle_q;
  logic              complete_c;
  logic              fire_c;
`ifdef SEG7_MON_MINUS_EN
  logic              minus_c;
  logic [AN_W-1:0]   sneg_q;
`endif

  // Input sync stage: one register on the scan inputs.
  always_ff @(posedge mclk) begin
    if (rst) begin
      seg_q <= '1;
      an_q  <= '1;
    end else begin
      seg_q <= seg;
      an_q  <= an;
    end
  end

  // The registered scan copy changes on this edge.
  assign change_c     = ({an, seg} != {an_q, seg_q});
  // Stability count reaches its target on this edge.
  assign settle_hit_c = !change_c && (cnt_q == STABLE_LAST);

  // Stability counter: clears on change, saturates at STABLE_CYCLES.
  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (change_c) begin
      cnt_q <= '0;
    end else if (cnt_q != STABLE_MAX) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge mclk) begin
    if (rst) state_q <= SETTLE;
    else     state_q <= state_d;
  end

  // FSM next state: any scan change restarts settling; a capture parks in HELD.
  always_comb begin
    state_d = state_q;
    if (change_c)       state_d = SETTLE;
    else if (capture_c) state_d = HELD;
  end

  // FSM output: one capture per dwell, only for a single active anode.
  always_comb begin
    capture_c = 1'b0;
    if ((state_q == SETTLE) && settle_hit_c && onehot_c) capture_c = 1'b1;
  end

  // Anode decode: digit index and single-active-anode flag.
  always_comb begin
    idx_c    = '0;
    onehot_c = 1'b0;
    case (an_q)
      4'b1110: begin idx_c = 2'd0; onehot_c = 1'b1; end
      4'b1101: begin idx_c = 2'd1; onehot_c = 1'b1; end
      4'b1011: begin idx_c = 2'd2; onehot_c = 1'b1; end
      4'b0111: begin idx_c = 2'd3; onehot_c = 1'b1; end
      default: begin idx_c = 2'd0; onehot_c = 1'b0; end
    endcase
  end

  // Segment decode (active-low, g..a) back to a nibble.
  always_comb begin
    nib_c   = '0;
    blank_c = 1'b0;
    bad_c   = 1'b0;
`ifdef SEG7_MON_MINUS_EN
    minus_c = 1'b0;
`endif
    case (seg_q)
      7'b1000000: nib_c = 4'h0;
      7'b1111001: nib_c = 4'h1;
      7'b0100100: nib_c = 4'h2;
      7'b0110000: nib_c = 4'h3;
      7'b0011001: nib_c = 4'h4;
      7'b0010010: nib_c = 4'h5;
      7'b0000010: nib_c = 4'h6;
      7'b1111000: nib_c = 4'h7;
      7'b0000000: nib_c = 4'h8;
      7'b0010000: nib_c = 4'h9;
      7'b0001000: nib_c = 4'hA;
      7'b0000011: nib_c = 4'hB;
      7'b1000110: nib_c = 4'hC;
      7'b0100001: nib_c = 4'hD;
      7'b0000110: nib_c = 4'hE;
      7'b0001110: nib_c = 4'hF;
      7'b1111111: blank_c = 1'b1;
`ifdef SEG7_MON_MINUS_EN
      7'b0111111: minus_c = 1'b1;
`endif
      default:    bad_c = 1'b1;
    endcase
  end

  assign complete_c = (seen_q == '1);
  // Idle counter hits TIMEOUT on this edge (a capture pre-empts it).
  assign fire_c     = !capture_c && (idle_q != IDLE_MAX) &&
                      ((idle_q + IDLE_W'(1)) == IDLE_MAX);

  // Frame assembly, publication and staleness timeout.
  always_ff @(posedge mclk) begin
    if (rst) begin
      value       <= '0;
      blank       <= '0;
      valid       <= 1'b0;
      frame_done  <= 1'b0;
      bad_seg     <= 1'b0;
      shadow_q    <= '0;
      sblank_q    <= '0;
      seen_q      <= '0;
      frame_bad_q <= 1'b0;
      idle_q      <= '0;
`ifdef SEG7_MON_MINUS_EN
      neg         <= '0;
      sneg_q      <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      bad_seg    <= 1'b0;
      if (capture_c)             idle_q <= '0;
      else if (idle_q != IDLE_MAX) idle_q <= idle_q + IDLE_W'(1);
      if (complete_c) begin
        value       <= shadow_q;
        blank       <= sblank_q;
        valid       <= !frame_bad_q;
        frame_done  <= 1'b1;
        shadow_q    <= '0;
        sblank_q    <= '0;
        seen_q      <= '0;
        frame_bad_q <= 1'b0;
`ifdef SEG7_MON_MINUS_EN
        neg         <= sneg_q;
        sneg_q      <= '0;
`endif
        if (fire_c) idle_q <= '0;
      end else if (fire_c) begin
        valid       <= 1'b0;
        seen_q      <= '0;
        frame_bad_q <= 1'b0;
      end
      if (capture_c) begin
        shadow_q[{idx_c, 2'b00} +: NIB_W] <= nib_c;
        sblank_q[idx_c] <= blank_c;
        seen_q[idx_c]   <= 1'b1;
`ifdef SEG7_MON_MINUS_EN
        sneg_q[idx_c]   <= minus_c;
`endif
        if (bad_c) begin
          frame_bad_q <= 1'b1;
          bad_seg     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_monitor.sv
// tb_seg7_scan_monitor: directed and randomized dwell-level stimulus for
// seg7_scan_monitor, checked against a dwell/event-based reference model.
`timescale 1ns/1ps

module tb_seg7_scan_monitor;

  localparam int unsigned STABLE = 4;
  localparam int unsigned TOUT   = 100;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        mclk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic [3:0]  blank;
  logic        valid;
  logic        frame_done;
  logic        bad_seg;
`ifdef SEG7_MON_MINUS_EN
  logic [3:0]  neg;
`endif

  seg7_scan_monitor #(.STABLE_CYCLES(STABLE), .TIMEOUT(TOUT)) dut (
    .mclk(mclk), .rst(rst), .seg(seg), .an(an),
    .value(value), .blank(blank), .valid(valid),
    .frame_done(frame_done), .bad_seg(bad_seg)
`ifdef SEG7_MON_MINUS_EN
    , .neg(neg)
`endif
  );

  always #5 mclk = ~mclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] m_value;
  logic [3:0]  m_blank, m_neg, m_valid_v;
  bit          m_valid, m_fd, m_bs, m_bad;
  logic [3:0]  m_seen;
  logic [3:0]  m_sh [4];
  bit          m_sb [4];
  bit          m_sn [4];
  int          m_idle;
  int          cyc = 0;
  int          last_cap_cyc = 0;
  logic [10:0] prev_in;

  // Observation counters
  int  fd_obs, bs_obs, fall_cyc;
  bit  valid_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void decode(input logic [6:0] s, output logic [3:0] nib,
                                 output bit blk, output bit mn, output bit bad);
    nib = 4'h0; blk = 1'b0; mn = 1'b0; bad = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (SEG_TBL[i] == s) begin nib = 4'(i); bad = 1'b0; end
    end
    if (s == 7'b1111111) begin blk = 1'b1; bad = 1'b0; end
`ifdef SEG7_MON_MINUS_EN
    if (s == 7'b0111111) begin mn = 1'b1; bad = 1'b0; end
`endif
  endfunction

  function automatic bit single_low(input logic [3:0] a);
    return $countones(~a) == 1;
  endfunction

  task automatic model_reset();
    m_value = '0; m_blank = '0; m_neg = '0; m_valid = 1'b0;
    m_fd = 1'b0; m_bs = 1'b0; m_bad = 1'b0; m_seen = '0; m_idle = 0;
    for (int i = 0; i < 4; i++) begin m_sh[i] = '0; m_sb[i] = 1'b0; m_sn[i] = 1'b0; end
  endtask

  // Advance the model by one mclk edge; cap says a digit is captured on it.
  task automatic model_step(input bit cap, input logic [3:0] a, input logic [6:0] s);
    bit fire;
    logic [3:0] nib;
    bit blk, mn, bad;
    int idx;
    m_fd = 1'b0; m_bs = 1'b0; fire = 1'b0;
    if (cap) m_idle = 0;
    else if (m_idle < TOUT) begin m_idle++; fire = (m_idle == TOUT); end
    if (m_seen == 4'hF) begin
      m_value = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
      m_blank = {m_sb[3], m_sb[2], m_sb[1], m_sb[0]};
      m_neg   = {m_sn[3], m_sn[2], m_sn[1], m_sn[0]};
      m_valid = !m_bad; m_fd = 1'b1; m_seen = '0; m_bad = 1'b0;
      for (int i = 0; i < 4; i++) begin m_sh[i] = '0; m_sb[i] = 1'b0; m_sn[i] = 1'b0; end
      if (fire) m_idle = 0;
    end else if (fire) begin
      m_valid = 1'b0; m_seen = '0; m_bad = 1'b0;
    end
    if (cap) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (a[i] == 1'b0) idx = i;
      decode(s, nib, blk, mn, bad);
      m_sh[idx] = nib; m_sb[idx] = blk; m_sn[idx] = mn; m_seen[idx] = 1'b1;
      if (bad) begin m_bad = 1'b1; m_bs = 1'b1; end
      last_cap_cyc = cyc;
    end
  endtask

  task automatic check_outputs();
    chk("value", 32'(value), 32'(m_value));
    chk("blank", 32'(blank), 32'(m_blank));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("bad_seg", 32'(bad_seg), 32'(m_bs));
`ifdef SEG7_MON_MINUS_EN
    chk("neg", 32'(neg), 32'(m_neg));
`endif
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; an = 4'hF; seg = 7'h7F;
    for (int k = 0; k < n; k++) begin
      @(posedge mclk); cyc++;
      model_reset();
      #1 check_outputs();
    end
    rst = 1'b0;
    prev_in = {4'hF, 7'h7F};
    valid_prev = 1'b0;
  endtask

  // Hold one {an,seg} pattern for L edges; a capture lands on the STABLE-th edge.
  task automatic run_dwell(input logic [3:0] a, input logic [6:0] s, input int L);
    for (int k = 0; k < L; k++) begin
      an = a; seg = s;
      @(posedge mclk); cyc++;
      model_step((k == STABLE) && (L >= STABLE + 1) && single_low(a), a, s);
      #1 check_outputs();
      if (frame_done) fd_obs++;
      if (bad_seg) bs_obs++;
      if (valid_prev && !valid) fall_cyc = cyc;
      valid_prev = valid;
    end
    prev_in = {a, s};
  endtask

  task automatic clear_obs();
    fd_obs = 0; bs_obs = 0; fall_cyc = -1;
  endtask

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int r, j, L;

    model_reset();
    do_reset(3);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);

    // Frame "--35" with two blank digits
    clear_obs();
    run_dwell(4'b1110, 7'b0010010, 20);
    run_dwell(4'b1101, 7'b0110000, 20);
    run_dwell(4'b1011, 7'b1111111, 20);
    run_dwell(4'b0111, 7'b1111111, 20);
    chk("t1_fd_count", 32'(fd_obs), 32'd1);
    chk("t1_value", 32'(value), 32'h0035);
    chk("t1_blank", 32'(blank), 32'b1100);
    chk("t1_valid", 32'(valid), 32'd1);

    // Glitching digit 0 never settles; the final long hold is captured once
    clear_obs();
    for (int g = 0; g < 6; g++) run_dwell(4'b1110, (g % 2 == 0) ? 7'b1111001 : 7'b1111000, 2);
    chk("t2_glitch_fd", 32'(fd_obs), 32'd0);
    run_dwell(4'b1110, 7'b0000000, 20);
    run_dwell(4'b1101, 7'b0010000, 20);
    run_dwell(4'b1011, 7'b0001000, 20);
    run_dwell(4'b0111, 7'b0000011, 20);
    chk("t2_fd_count", 32'(fd_obs), 32'd1);
    chk("t2_value", 32'(value), 32'hBA98);
    chk("t2_valid", 32'(valid), 32'd1);

    // Undecodable pattern on digit 2
    clear_obs();
    run_dwell(4'b1110, 7'b1111001, 20);
    run_dwell(4'b1101, 7'b0100100, 20);
    run_dwell(4'b1011, 7'b1111110, 20);
    run_dwell(4'b0111, 7'b0011001, 20);
    chk("t3_bad_count", 32'(bs_obs), 32'd1);
    chk("t3_value", 32'(value), 32'h4021);
    chk("t3_valid", 32'(valid), 32'd0);

    // Two anodes low mid-frame is ignored
    clear_obs();
    run_dwell(4'b1110, 7'b1000110, 20);
    run_dwell(4'b1101, 7'b0100001, 20);
    run_dwell(4'b0011, 7'b0000110, 50);
    chk("t4_multi_fd", 32'(fd_obs), 32'd0);
    chk("t4_multi_bad", 32'(bs_obs), 32'd0);
    run_dwell(4'b1011, 7'b0000110, 20);
    run_dwell(4'b0111, 7'b0001110, 20);
    chk("t4_value", 32'(value), 32'hFEDC);
    chk("t4_valid", 32'(valid), 32'd1);

    // Staleness timeout after the last capture
    clear_obs();
    run_dwell(4'b1110, 7'b1000000, 20);
    run_dwell(4'b1101, 7'b1111001, 20);
    run_dwell(4'b1011, 7'b0100100, 20);
    run_dwell(4'b0111, 7'b0110000, 20);
    run_dwell(4'b1111, 7'b1111111, 120);
    chk("t5_timeout_gap", 32'(fall_cyc - last_cap_cyc), 32'd100);
    chk("t5_value_kept", 32'(value), 32'h3210);
    chk("t5_valid", 32'(valid), 32'd0);

    // Minus sign on digit 3
    clear_obs();
    run_dwell(4'b1110, 7'b1111001, 20);
    run_dwell(4'b1101, 7'b1000000, 20);
    run_dwell(4'b1011, 7'b1000000, 20);
    run_dwell(4'b0111, 7'b0111111, 20);
    chk("t6_value", 32'(value), 32'h0001);
`ifdef SEG7_MON_MINUS_EN
    chk("t6_neg", 32'(neg), 32'b1000);
    chk("t6_valid", 32'(valid), 32'd1);
    chk("t6_bad_count", 32'(bs_obs), 32'd0);
`else
    chk("t6_valid", 32'(valid), 32'd0);
    chk("t6_bad_count", 32'(bs_obs), 32'd1);
`endif

    // Reset mid-frame discards partial digits
    run_dwell(4'b1110, 7'b1111000, 20);
    run_dwell(4'b1101, 7'b1111000, 20);
    do_reset(2);
    clear_obs();
    run_dwell(4'b1011, 7'b0000010, 20);
    run_dwell(4'b0111, 7'b0000010, 20);
    chk("t7_partial_fd", 32'(fd_obs), 32'd0);
    run_dwell(4'b1110, 7'b0010010, 20);
    run_dwell(4'b1101, 7'b0010010, 20);
    chk("t7_fd_count", 32'(fd_obs), 32'd1);
    chk("t7_value", 32'(value), 32'h6655);

    // Randomized dwells against the model
    for (int d = 0; d < 400; d++) begin
      r = $urandom_range(0, 9);
      if (r <= 6) begin a = 4'hF; j = $urandom_range(0, 3); a[j] = 1'b0; end
      else if (r == 7) a = 4'hF;
      else a = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r <= 7) begin j = $urandom_range(0, 15); s = SEG_TBL[j]; end
      else if (r == 8) s = 7'h7F;
      else s = 7'($urandom);
      if ({a, s} == prev_in) s = s ^ 7'h01;
      L = ($urandom_range(0, 19) == 0) ? $urandom_range(100, 130) : $urandom_range(1, 10);
      run_dwell(a, s, L);
      if ($urandom_range(0, 49) == 0) do_reset(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
